// File: rtl/bp_lce_req_arb.sv
// bp_lce_req_arb
//   Shares one LCE request network port between num_req_p request sources (for
//   example the I$ and D$ LCE request handlers of a tile). A round-robin arbiter
//   feeds a one-entry registered output stage. Each source has its own
//   outstanding-request credit counter, so one source can be throttled without
//   stalling the others.
//
// Parameters
//   num_req_p            number of request sources (>= 2)
//   credits_p            max outstanding requests per source
//   lce_req_msg_width_p  width of one LCE request message
//
// Ports
//   clk_i                clock, all state updates on posedge
//   reset_n_i            asynchronous active-low reset
//   req_i                source messages, source k in slice k
//   req_v_i              source valid
//   req_ready_and_o      source k accepted when req_v_i[k] & req_ready_and_o[k]
//   credit_return_i      one pulse per completed request of source k
//   credits_full_o       count[k] == credits_p
//   credits_empty_o      count[k] == 0
//   lce_req_o            registered message to the network
//   lce_req_v_o          registered valid
//   lce_req_ready_and_i  network accepts when lce_req_v_o & lce_req_ready_and_i
module bp_lce_req_arb #(
   parameter int unsigned num_req_p           = 2,
   parameter int unsigned credits_p           = 4,
   parameter int unsigned lce_req_msg_width_p = 64
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   input  logic [num_req_p*lce_req_msg_width_p-1:0] req_i,
   input  logic [num_req_p-1:0]                     req_v_i,
   output logic [num_req_p-1:0]                     req_ready_and_o,
   input  logic [num_req_p-1:0]                     credit_return_i,
   output logic [num_req_p-1:0]                     credits_full_o,
   output logic [num_req_p-1:0]                     credits_empty_o,
   output logic [lce_req_msg_width_p-1:0]           lce_req_o,
   output logic                                     lce_req_v_o,
   input  logic                                     lce_req_ready_and_i
);

   localparam int unsigned cnt_width_lp = $clog2(credits_p + 1);
   localparam int unsigned idx_width_lp = $clog2(num_req_p);

   logic [cnt_width_lp-1:0]        count_r [num_req_p];
   logic [idx_width_lp-1:0]        last_r;
   logic [lce_req_msg_width_p-1:0] data_r;
   logic                           v_r;

   logic [num_req_p-1:0]           elig;
   logic [num_req_p-1:0]           grant;
   logic [idx_width_lp-1:0]        grant_idx;
   logic                           grant_found;
   logic                           space;
   logic                           accept;
   logic [lce_req_msg_width_p-1:0] sel_msg;
   logic [num_req_p-1:0]           inc;

   // Credit status and eligibility
   always_comb begin
      credits_full_o  = '0;
      credits_empty_o = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         credits_full_o[k]  = (count_r[k] == cnt_width_lp'(credits_p));
         credits_empty_o[k] = (count_r[k] == '0);
      end
   end

   assign elig  = req_v_i & ~credits_full_o;
   assign space = ~v_r | lce_req_ready_and_i;

   // Round-robin search starting just after the last granted source
   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int unsigned i = 1; i <= num_req_p; i++) begin
         idx = 32'(last_r) + i;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!grant_found && elig[idx]) begin
            grant_found = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = idx_width_lp'(idx);
         end
      end
   end

   always_comb begin
      sel_msg = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         if (grant[k]) sel_msg = req_i[k*lce_req_msg_width_p +: lce_req_msg_width_p];
      end
   end

   // Ready is gated by reset so nothing is handshaken while the block is held in reset
   assign req_ready_and_o = grant & {num_req_p{space & reset_n_i}};
   assign accept          = space & grant_found & reset_n_i;
   assign inc             = req_v_i & req_ready_and_o;

   // One-entry output stage; a drain and a new accept in the same cycle reload it
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_r    <= 1'b0;
         data_r <= '0;
         last_r <= idx_width_lp'(num_req_p - 1);
      end else if (accept) begin
         v_r    <= 1'b1;
         data_r <= sel_msg;
         last_r <= grant_idx;
      end else if (lce_req_ready_and_i) begin
         v_r    <= 1'b0;
      end
   end

   // Credits are consumed at accept, not at network drain
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int unsigned k = 0; k < num_req_p; k++) count_r[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < num_req_p; k++) begin
            if (inc[k] && !credit_return_i[k]) begin
               count_r[k] <= count_r[k] + 1'b1;
            end else if (credit_return_i[k] && !inc[k] && (count_r[k] != '0)) begin
               count_r[k] <= count_r[k] - 1'b1;
            end
         end
      end
   end

   // A credit return with nothing outstanding indicates a protocol bug upstream
   always_ff @(posedge clk_i) begin
      for (int unsigned k = 0; k < num_req_p; k++) begin
         assert (!(reset_n_i && credit_return_i[k] && (count_r[k] == '0)))
            else $error("bp_lce_req_arb: credit return on source %0d with zero count", k);
      end
   end

   assign lce_req_o   = data_r;
   assign lce_req_v_o = v_r;

endmodule

// File: tb/tb_bp_lce_req_arb.sv
// tb_bp_lce_req_arb
//   Directed bench for bp_lce_req_arb with two sources, 16-bit messages and
//   four credits. A small reference model predicts grants, credit state and the
//   output stage; accepted messages are queued and compared when drained.
module tb_bp_lce_req_arb;

   localparam int N = 2;
   localparam int W = 16;
   localparam int C = 4;

   logic           clk_i = 1'b0;
   logic           reset_n_i;
   logic [N*W-1:0] req_i;
   logic [N-1:0]   req_v_i;
   logic [N-1:0]   req_ready_and_o;
   logic [N-1:0]   credit_return_i;
   logic [N-1:0]   credits_full_o;
   logic [N-1:0]   credits_empty_o;
   logic [W-1:0]   lce_req_o;
   logic           lce_req_v_o;
   logic           lce_req_ready_and_i;

   bp_lce_req_arb #(
      .num_req_p           (N),
      .credits_p           (C),
      .lce_req_msg_width_p (W)
   ) dut (
      .clk_i               (clk_i),
      .reset_n_i           (reset_n_i),
      .req_i               (req_i),
      .req_v_i             (req_v_i),
      .req_ready_and_o     (req_ready_and_o),
      .credit_return_i     (credit_return_i),
      .credits_full_o      (credits_full_o),
      .credits_empty_o     (credits_empty_o),
      .lce_req_o           (lce_req_o),
      .lce_req_v_o         (lce_req_v_o),
      .lce_req_ready_and_i (lce_req_ready_and_i)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int           m_cnt [N];
   int           m_last;
   bit           m_v;
   logic [W-1:0] sb_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
         else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_last = N - 1;
      m_v    = 1'b0;
      sb_q.delete();
   endtask

   task automatic set_req(input logic [W-1:0] m0, input logic [W-1:0] m1);
      req_i = {m1, m0};
   endtask

   // Inputs are driven just after a negedge; this checks one cycle and advances to the next negedge.
   task automatic tick(input string tag);
      logic [N-1:0] elig, exp_rdy, m_full, m_empty;
      bit           space;
      int           g;
      int           idx;
      #1;
      for (int k = 0; k < N; k++) begin
         m_full[k]  = (m_cnt[k] == C);
         m_empty[k] = (m_cnt[k] == 0);
         elig[k]    = req_v_i[k] & ~m_full[k];
      end
      space   = !m_v || lce_req_ready_and_i;
      exp_rdy = '0;
      g       = -1;
      for (int i = 1; i <= N; i++) begin
         idx = (m_last + i) % N;
         if (g < 0 && elig[idx]) g = idx;
      end
      if (space && g >= 0) exp_rdy[g] = 1'b1;

      chk({tag, ".ready"}, 32'(req_ready_and_o), 32'(exp_rdy));
      chk({tag, ".valid"}, 32'(lce_req_v_o), 32'(m_v));
      chk({tag, ".full"},  32'(credits_full_o), 32'(m_full));
      chk({tag, ".empty"}, 32'(credits_empty_o), 32'(m_empty));
      if (m_v) begin
         tests++;
         assert (sb_q.size() != 0)
            else begin
               fails++;
               $error("FAIL %s.sb: observed output %0h expected no queued message", tag, lce_req_o);
            end
         if (sb_q.size() != 0) begin
            chk({tag, ".data"}, 32'(lce_req_o), 32'(sb_q[0]));
            if (lce_req_ready_and_i) void'(sb_q.pop_front());
         end
      end

      if (exp_rdy != '0) begin
         sb_q.push_back(req_i[g*W +: W]);
         m_v    = 1'b1;
         m_last = g;
      end else if (lce_req_ready_and_i) begin
         m_v = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         if (exp_rdy[k] && !credit_return_i[k]) m_cnt[k]++;
         else if (credit_return_i[k] && !exp_rdy[k] && m_cnt[k] > 0) m_cnt[k]--;
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      req_v_i = '0;
      credit_return_i = '0;
      model_reset();
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   initial begin
      reset_n_i           = 1'b0;
      req_i               = '0;
      req_v_i             = '0;
      credit_return_i     = '0;
      lce_req_ready_and_i = 1'b0;
      model_reset();
      @(negedge clk_i);

      // Reset state; ready must stay low even with both sources valid
      req_v_i = 2'b11;
      #1;
      chk("rst.ready", 32'(req_ready_and_o), 32'h0);
      chk("rst.valid", 32'(lce_req_v_o), 32'h0);
      chk("rst.data",  32'(lce_req_o), 32'h0);
      chk("rst.empty", 32'(credits_empty_o), 32'h3);
      chk("rst.full",  32'(credits_full_o), 32'h0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // T1: single request from source 0
      req_v_i = 2'b01;
      set_req(16'hA00A, 16'h0000);
      lce_req_ready_and_i = 1'b1;
      tick("t1.acc");
      req_v_i = '0;
      tick("t1.out");
      chk("t1.empty", 32'(credits_empty_o), 32'h2);
      credit_return_i = 2'b01;
      tick("t1.ret");
      credit_return_i = '0;

      // T2: both sources every cycle until credits run out
      do_reset();
      req_v_i = 2'b11;
      for (int i = 0; i < 10; i++) begin
         set_req(16'h1000 + 16'(i), 16'h2000 + 16'(i));
         tick("t2");
      end
      chk("t2.full", 32'(credits_full_o), 32'h3);

      // T4: return on a full source blocks it this cycle, accepted next cycle
      req_v_i = 2'b01;
      credit_return_i = 2'b01;
      set_req(16'h4444, 16'h0000);
      tick("t4.ret");
      credit_return_i = '0;
      set_req(16'h4445, 16'h0000);
      tick("t4.acc");
      req_v_i = '0;
      tick("t4.idle");
      chk("t4.full", 32'(credits_full_o), 32'h3);

      // T5: bring source 1 down to 2, then accept and return together
      credit_return_i = 2'b10;
      tick("t5.ret1");
      tick("t5.ret2");
      req_v_i = 2'b10;
      set_req(16'h0000, 16'h5555);
      tick("t5.both");
      req_v_i = '0;
      credit_return_i = '0;
      tick("t5.idle");
      chk("t5.empty", 32'(credits_empty_o), 32'h0);
      chk("t5.full",  32'(credits_full_o), 32'h1);

      // T3: network stall holds B, then ready returns and source 1 is accepted
      req_v_i = 2'b10;
      set_req(16'h0000, 16'hBBBB);
      tick("t3.loadB");
      lce_req_ready_and_i = 1'b0;
      set_req(16'h0000, 16'hCCCC);
      for (int i = 0; i < 5; i++) tick("t3.stall");
      chk("t3.holdB", 32'(lce_req_o), 32'hBBBB);
      lce_req_ready_and_i = 1'b1;
      tick("t3.resume");
      req_v_i = '0;
      tick("t3.drain");

      // T6: asynchronous reset mid-cycle with output valid and counts nonzero
      credit_return_i = 2'b11;
      tick("t6.ret");
      credit_return_i = '0;
      lce_req_ready_and_i = 1'b0;
      req_v_i = 2'b01;
      set_req(16'h6666, 16'h0000);
      tick("t6.load");
      chk("t6.pre_v", 32'(lce_req_v_o), 32'h1);
      req_v_i = 2'b11;
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("t6.v",     32'(lce_req_v_o), 32'h0);
      chk("t6.empty", 32'(credits_empty_o), 32'h3);
      chk("t6.ready", 32'(req_ready_and_o), 32'h0);
      chk("t6.data",  32'(lce_req_o), 32'h0);
      model_reset();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      lce_req_ready_and_i = 1'b1;
      set_req(16'h7000, 16'h7001);
      #1;
      chk("t6.first", 32'(req_ready_and_o), 32'h1);
      #1;
      tick("t6.g0");
      tick("t6.g1");
      req_v_i = '0;
      tick("t6.idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
